gc_tstamp_sched: RTL
====================

# gc_tstamp_sched

Frame timing sequencer and timestamp arbiter for the audio datapath. Owns an internal Gray-coded frame counter and sequences it through idle, armed and running phases, aligned to an external frame sync. Shares the counter's Gray timestamp among NREQ requesters (packet TX, packet RX, I2S), one snapshot grant per cycle. Sits between the network frame-sync recovery logic and the sample-path blocks that tag data with frame position.

## Interface
- NREQ, 4, number of timestamp requesters (2..8)
- CW, 8, counter and timestamp width
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  level; low forces IDLE
- sync_in  in  1  single-cycle frame sync pulse
- period  in  CW  last count value of a frame; frame length = period+1
- req  in  NREQ  level timestamp requests
- gnt  out  NREQ  one-hot grant pulse
- ts_gray  out  CW  Gray timestamp, valid while any gnt bit is high
- frame_tick  out  1  pulse on first cycle of each frame (cnt==0)
- sync_err  out  1  pulse: sync_in arrived off the expected boundary
- running  out  1  high in RUN

## Operation
- Reset: state IDLE; cnt=0, period_q=0; gnt, ts_gray, frame_tick, sync_err, running all 0.
- States:
  - IDLE: cnt held 0, no grants. Moves to ARM when enable=1.
  - ARM: cnt held 0, no grants. Moves to RUN on sync_in: period_q<=period, cnt<=0, frame_tick<=1.
  - RUN: cnt increments by 1 per cycle. At cnt==period_q: cnt<=0, period_q<=period, frame_tick<=1.
- enable=0 in any state: IDLE next cycle, cnt<=0, and no grant is issued in that cycle. enable has priority over sync_in.
- sync_in in RUN:
  - cnt==period_q: normal wrap, no error.
  - cnt!=period_q: forced wrap (cnt<=0, period_q<=period, frame_tick<=1) and sync_err<=1.
- Gray coding: ts = cnt ^ (cnt>>1), CW bits, unsigned; cnt never exceeds period_q.
- period=0: cnt stays 0 and frame_tick is high every cycle in RUN.
- period changes mid-frame are ignored until the next wrap or forced wrap.
- Arbitration, RUN only:
  - Eligible = req masked by the current gnt, so a requester is ignored in its own grant cycle.
  - One winner per cycle. gnt[i] and ts_gray (Gray of cnt in the sampling cycle) are registered.
  - Requesters hold req until they see gnt, then drop it. A req still high one cycle after gnt counts as a new request.
  - Pending requests in IDLE/ARM are held off, not lost; they are served once RUN is entered.

## Timing
- All outputs registered; no combinational input-to-output paths.
- req at cycle N, uncontended, in RUN: gnt and ts_gray = gray(cnt@N) at N+1.
- sync_in at N in ARM: at N+1 running=1, cnt=0, frame_tick=1.
- sync_err and frame_tick are 1-cycle pulses at N+1 after the causing edge.
- Rate limits: one grant per requester per 2 cycles; aggregate one grant per cycle.

## Configuration
- GC_TSTAMP_SCHED_RR_EN:
  - Defined: round-robin arbitration. The pointer moves to one past the last winner, so any requester waits at most NREQ grants.
  - Undefined: fixed priority, with req[0] highest.

## Structure
- Package gc_tstamp_pkg: state enum (ST_IDLE, ST_ARM, ST_RUN), default CW/NREQ constants, function bin2gray.
- Sub-module gc_rr_arb: parameterized NREQ arbiter with one-hot grant output and pointer update on a grant-valid input. Fixed-priority vs round-robin is selected inside it by the macro.
- Top level holds the FSM, counter, period latch, and output registers.

## Test plan
- Reset/arm: rst, then enable=1, period=3, sync_in at cycle 10 -> cycle 11 running=1, cnt sequence 0,1,2,3,0; frame_tick at cycles 11 and 15; gray ts 0,1,3,2.
- Off-boundary sync: RUN with period=7, sync_in at cnt=4 -> next cycle cnt=0, frame_tick=1, sync_err=1. sync_in at cnt=7 -> sync_err=0.
- Period change: period 7→2 while cnt=3 -> cnt continues to 7, then frames of 3 cycles. period=0 -> frame_tick stuck high.
- Contention, RR defined: req=4'b1111 held, each requester drops req on its own gnt and re-raises it next cycle -> grants 0,1,2,3,0; each ts_gray = gray(cnt one cycle earlier).
- Contention, macro undefined: req[0] and req[2] held -> gnt[0] on alternate cycles, gnt[2] in the gaps.
- Abort: enable=0 during RUN with req pending -> next cycle IDLE, cnt=0, no gnt. Re-enable plus sync_in -> pending req granted on the first RUN cycle+1.

Source files
------------

// File: rtl/gc_tstamp_pkg.sv
// Shared types and helpers for the frame timing sequencer / timestamp arbiter.
// Optional round-robin arbitration is enabled by defining GC_TSTAMP_SCHED_RR_EN.
package gc_tstamp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN
  } state_e;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned CW_DEF   = 8;

  // Callers truncate the result to their own counter width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gc_tstamp_sched_if.sv
// Timestamp request/grant bundle shared by the requesters and the scheduler.
interface gc_tstamp_sched_if
  import gc_tstamp_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned CW   = CW_DEF
) ();

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [CW-1:0]   ts_gray;

  modport master (output req, input gnt, input ts_gray);
  modport slave  (input req, output gnt, output ts_gray);

endinterface

// File: rtl/gc_rr_arb.sv
// NREQ-way one-hot arbiter. Round-robin when GC_TSTAMP_SCHED_RR_EN is defined,
// otherwise fixed priority with req[0] highest (pointer pinned at 0).
module gc_rr_arb
  import gc_tstamp_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic          found;

  // Search starts at ptr_q and wraps; first asserted request wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    ptr_d = ptr_q;
    for (int off = 0; off < NREQ; off++) begin
      idx = PW'((int'(ptr_q) + off) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        if (en) begin
`ifdef GC_TSTAMP_SCHED_RR_EN
          ptr_d = PW'((int'(idx) + 1) % NREQ);
`else
          ptr_d = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gc_tstamp_sched.sv
// Frame sequencer with Gray-coded frame counter and timestamp grant arbitration.
// Arbitration policy follows GC_TSTAMP_SCHED_RR_EN (see gc_rr_arb).
module gc_tstamp_sched
  import gc_tstamp_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          sync_in,
  input  logic [CW-1:0] period,
  gc_tstamp_sched_if.slave bus,
  output logic          frame_tick,
  output logic          sync_err,
  output logic          running
);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   period_q, period_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]   ts_q, ts_d;
  logic            tick_q, tick_d;
  logic            err_q, err_d;
  logic            issue;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] arb_gnt;

  // A requester still holding req in its own grant cycle is not re-served.
  assign elig = bus.req & ~gnt_q;

  gc_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .req(elig),
    .en (issue),
    .gnt(arb_gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    gnt_d    = '0;
    ts_d     = ts_q;
    tick_d   = 1'b0;
    err_d    = 1'b0;
    issue    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
        ST_ARM: begin
          cnt_d = '0;
          if (sync_in) begin
            state_d  = ST_RUN;
            period_d = period;
            tick_d   = 1'b1;
          end
        end
        ST_RUN: begin
          issue = 1'b1;
          gnt_d = arb_gnt;
          if (|arb_gnt) ts_d = CW'(bin2gray(32'(cnt_q)));
          // Natural wrap and sync-forced wrap share the reload path.
          if (cnt_q == period_q || sync_in) begin
            cnt_d    = '0;
            period_d = period;
            tick_d   = 1'b1;
            err_d    = sync_in && (cnt_q != period_q);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      gnt_q    <= '0;
      ts_q     <= '0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      gnt_q    <= gnt_d;
      ts_q     <= ts_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ts_gray = ts_q;
  assign frame_tick  = tick_q;
  assign sync_err    = err_q;
  assign running     = (state_q == ST_RUN);

endmodule
